// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg
// Shared definitions for the multi-cycle MIPS main control unit and the
// EXECUTE-stage ALU control decoder: opcode constants, the controller state
// codes, and the encodings of alu_op, alu_src_b and pc_source.
// No ports; import with "import mips_ctrl_pkg::*;".

package mips_ctrl_pkg;

    // Primary opcodes (instruction[31:26]) understood by the controller
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // Controller states; the numeric codes are visible on the debug port
    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_ALU_WB    = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_t;

    // alu_op codes consumed by the ALU control decoder (2'b11 is reserved)
    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    // ALU B operand select
    localparam logic [1:0] SRC_B_RT      = 2'b00;
    localparam logic [1:0] SRC_B_FOUR    = 2'b01;
    localparam logic [1:0] SRC_B_IMM     = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

    // Next-PC select
    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    // True for every opcode the controller knows how to sequence
    function automatic logic isLegalOpcode(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ)   || (op == OP_J)  || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/multicycle_control.sv
// multicycle_control
// Main control FSM of the multi-cycle MIPS core. Walks each instruction
// through fetch, decode, execute, memory and write-back states and decodes
// every datapath enable from the current state. FETCH, MEM_READ and
// MEM_WRITE stall on mem_ready so wait-stated memory is supported.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   opcode[5:0]       instruction[31:26], only looked at in DECODE
//   mem_ready         memory finished the current access this cycle
//   pc_write, pc_write_cond, ir_write        PC / IR write enables
//   i_or_d            memory address select (0 = PC, 1 = ALUOut)
//   mem_read, mem_write                      memory strobes
//   mem_to_reg, reg_dst, reg_write           register-file write controls
//   alu_src_a         ALU A select (0 = PC, 1 = rs)
//   alu_src_b[1:0]    ALU B select (rt / 4 / imm / imm<<2)
//   alu_op[1:0]       add / subtract / use funct
//   pc_source[1:0]    ALU result / ALUOut / jump target
//   retire            pulse in the last cycle of each instruction
//   illegal_op        pulse when DECODE sees an unsupported opcode
//   state[3:0]        current state code for debug

module multicycle_control
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       ir_write,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       retire,
    output logic       illegal_op,
    output logic [3:0] state
);

    state_t     r_state;
    state_t     w_nextState;
    logic [5:0] r_opcode;

    // State register; reset drops straight back to FETCH, abandoning
    // whatever instruction was in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Opcode copy taken in DECODE so MEM_ADDR can pick read vs write even
    // though the instruction register may be changing underneath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_opcode <= 6'd0;
        end else if (r_state == S_DECODE) begin
            r_opcode <= opcode;
        end
    end

    // Next-state logic; illegal opcodes and unreachable codes go to FETCH
    always_comb begin
        w_nextState = S_FETCH;
        case (r_state)
            S_FETCH:     w_nextState = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: w_nextState = S_MEM_ADDR;
                    OP_RTYPE:     w_nextState = S_EXECUTE;
                    OP_BEQ:       w_nextState = S_BRANCH;
                    OP_J:         w_nextState = S_JUMP;
                    OP_ADDI:      w_nextState = S_ADDI_EXEC;
                    default:      w_nextState = S_FETCH;
                endcase
            end
            S_MEM_ADDR:  w_nextState = (r_opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  w_nextState = mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WB:    w_nextState = S_FETCH;
            S_MEM_WRITE: w_nextState = mem_ready ? S_FETCH : S_MEM_WRITE;
            S_EXECUTE:   w_nextState = S_ALU_WB;
            S_ALU_WB:    w_nextState = S_FETCH;
            S_BRANCH:    w_nextState = S_FETCH;
            S_JUMP:      w_nextState = S_FETCH;
            S_ADDI_EXEC: w_nextState = S_ADDI_WB;
            S_ADDI_WB:   w_nextState = S_FETCH;
            default:     w_nextState = S_FETCH;
        endcase
    end

    // Output decode. Reset masks everything so the FETCH strobes do not
    // leak out while the state register is held at FETCH. The FETCH write
    // enables and the MEM_WRITE retire follow mem_ready combinationally.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        ir_write      = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRC_B_RT;
        alu_op        = ALU_OP_ADD;
        pc_source     = PC_SRC_ALU;
        retire        = 1'b0;
        illegal_op    = 1'b0;
        if (!rst) begin
            case (r_state)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = SRC_B_FOUR;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: begin
                    alu_src_b = SRC_B_IMM_SH2;
                    if (!isLegalOpcode(opcode)) begin
                        illegal_op = 1'b1;
                        retire     = 1'b1;
                    end
                end
                S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRC_B_IMM;
                end
                S_MEM_READ: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                S_MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    retire     = 1'b1;
                end
                S_MEM_WRITE: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                    retire    = mem_ready;
                end
                S_EXECUTE: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_OP_FUNCT;
                end
                S_ALU_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                    retire    = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = ALU_OP_SUB;
                    pc_write_cond = 1'b1;
                    pc_source     = PC_SRC_ALUOUT;
                    retire        = 1'b1;
                end
                S_JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = PC_SRC_JUMP;
                    retire    = 1'b1;
                end
                S_ADDI_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRC_B_IMM;
                end
                S_ADDI_WB: begin
                    reg_write = 1'b1;
                    retire    = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign state = r_state;

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle main control unit for the MIPS core. Sequences each instruction through fetch, decode, execute, memory and write-back states, and drives every datapath enable, including the 2-bit `alu_op` consumed by the EXECUTE-stage ALU control decoder. Memory-facing states stall on a ready handshake, so the block works with both single-cycle and wait-stated memory.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous reset, active-high
- `opcode`  in  6  instruction[31:26] from the instruction register; sampled only in DECODE
- `mem_ready`  in  1  memory has completed the current read or write this cycle
- `pc_write`, `pc_write_cond`, `ir_write`  out  1  PC and IR write enables
- `i_or_d`  out  1  memory address source: 0 = PC, 1 = ALUOut
- `mem_read`, `mem_write`  out  1  memory strobes
- `mem_to_reg`, `reg_dst`, `reg_write`  out  1  register-file write controls
- `alu_src_a`  out  1  ALU A source: 0 = PC, 1 = rs
- `alu_src_b`  out  2  ALU B source: 00 = rt, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- `alu_op`  out  2  00 = add, 01 = subtract, 10 = use funct; 11 is never driven
- `pc_source`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- `retire`  out  1  one-cycle pulse in the final cycle of each instruction
- `illegal_op`  out  1  one-cycle pulse when DECODE sees an unsupported opcode
- `state`  out  4  current state code, for debug

## Operation
- Opcodes: R = 000000, LW = 100011, SW = 101011, BEQ = 000100, J = 000010, ADDI = 001000.
- Outputs are decoded from state. Any output not listed for a state is 0.
- FETCH (0): `mem_read`=1, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=00, `pc_source`=00.
  - `ir_write` and `pc_write` equal `mem_ready` (Mealy).
  - Advance to DECODE when `mem_ready`=1; otherwise hold.
- DECODE (1): `alu_src_a`=0, `alu_src_b`=11, `alu_op`=00.
  - Next state: LW/SW → MEM_ADDR; R → EXECUTE; BEQ → BRANCH; J → JUMP; ADDI → ADDI_EXEC.
  - Any other opcode → FETCH, with `illegal_op`=1 and `retire`=1 in this cycle.
- MEM_ADDR (2): `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. Next state: LW → MEM_READ, SW → MEM_WRITE. The opcode is held in an internal register captured in DECODE.
- MEM_READ (3): `mem_read`=1, `i_or_d`=1. Hold until `mem_ready`, then go to MEM_WB.
- MEM_WB (4): `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0, `retire`=1. Next state: FETCH.
- MEM_WRITE (5): `mem_write`=1, `i_or_d`=1. Hold until `mem_ready`. `retire`=`mem_ready`. Then go to FETCH.
- EXECUTE (6): `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10. Next state: ALU_WB.
- ALU_WB (7): `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0, `retire`=1. Next state: FETCH.
- BRANCH (8): `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_write_cond`=1, `pc_source`=01, `retire`=1. Next state: FETCH.
- JUMP (9): `pc_write`=1, `pc_source`=10, `retire`=1. Next state: FETCH.
- ADDI_EXEC (10): `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. Next state: ADDI_WB.
- ADDI_WB (11): `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0, `retire`=1. Next state: FETCH.
- State codes 12–15 are unreachable. If entered, the next state is FETCH and all outputs are 0.

## Timing
- Reset:
  - `rst`=1 forces `state` to FETCH immediately (asynchronous).
  - While `rst`=1, every output except `state` is forced to 0, including the FETCH strobes.
  - Reset asserted mid-instruction abandons it: no `retire`, and no partial write occurs after assertion.
- First fetch: `mem_read`=1 in the first cycle after `rst` falls.
- Cycles per instruction with `mem_ready` held at 1: R 4, LW 5, SW 4, BEQ 3, J 3, ADDI 4, illegal 2.
- Each cycle of `mem_ready`=0 in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle.
- `opcode` is ignored outside DECODE.
- `mem_ready` is ignored outside FETCH, MEM_READ and MEM_WRITE.
- `retire` pulses exactly once per instruction.

## Structure
- Package `mips_ctrl_pkg` holds:
  - opcode constants;
  - the state enum (4-bit, codes as listed above);
  - the `alu_op` codes, shared with the ALU control decoder;
  - the `alu_src_b` and `pc_source` encodings.
- Single flat module: a state register, a next-state process and an output decode. No sub-module is warranted.

## Test plan
- Reset, then R-type with `mem_ready`=1 → states 0,1,6,7,0. `alu_op`=10 only in state 6. `reg_write`=1 with `reg_dst`=1 in state 7. `retire` pulses in cycle 4.
- LW with 2 wait cycles in FETCH and 1 wait cycle in MEM_READ → 8 cycles total. `ir_write`/`pc_write` high only in the FETCH cycle where `mem_ready`=1. `mem_to_reg`=1 in MEM_WB.
- BEQ → 3 cycles. In cycle 3: `alu_op`=01, `pc_write_cond`=1, `pc_source`=01. SW → `mem_write` held through wait cycles, and `retire` coincides with `mem_ready`.
- Opcode 111111 in DECODE → `illegal_op` and `retire` pulse together, next state FETCH, and no write enable asserted at any point.
- Assert `rst` in MEM_READ → `state`=0 and all strobes 0 in the same cycle. After `rst` falls, a fresh fetch starts with `mem_read`=1.
- J then ADDI back-to-back → 3 + 4 cycles. `pc_source`=10 with `pc_write`=1 in JUMP. `alu_src_b`=10 in ADDI_EXEC. `alu_op` never equals 11 across the whole run.
